mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit that sits beside the datapath as the HI/LO producer. It responds to the control unit's MDCtrl/start request, running a 32-iteration shift-add multiply or restoring divide. It raises a combinational div0 flag and delivers HI/LO with a one-cycle done pulse. Latency is fixed and well under the controller's 40-cycle wait window.

---
 rtl/mdu_pkg.sv | 8 +
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 92 +++++++++
 tb/tb_mult_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and timing constants for the multiply/divide unit
package mdu_pkg;
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV = 1'b1;
  localparam int MDU_ITER = 32;
  localparam int MDU_LATENCY = 33;
  typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control unit and the multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic MDCtrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic busy;
  logic done;
  logic div0;
  modport master(output start, MDCtrl, a, b, input hi, lo, busy, done, div0);
  modport slave(input start, MDCtrl, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed shift-add multiply / restoring divide producing HI/LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  mult_div_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e state, state_n;
  logic op, op_n, sa, sa_n, sb, sb_n, done, done_n, ge;
  logic [WIDTH-1:0] acc, acc_n, mq, mq_n, opb, opb_n, hi, hi_n, lo, lo_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH:0] sum, shl, diff;
  logic [2*WIDTH-1:0] prod;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
  // acc doubles as the upper product half / remainder, mq as multiplier / quotient
  always_comb begin
    state_n = state;
    op_n = op;
    sa_n = sa;
    sb_n = sb;
    acc_n = acc;
    mq_n = mq;
    opb_n = opb;
    cnt_n = cnt;
    hi_n = hi;
    lo_n = lo;
    done_n = 1'b0;
    sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
    shl = {acc, mq[WIDTH-1]};
    diff = shl - {1'b0, opb};
    ge = !diff[WIDTH];
    prod = (sa ^ sb) ? -{acc, mq} : {acc, mq};
    if (state == IDLE && md.start && !md.div0) begin
      op_n = md.MDCtrl;
      sa_n = md.a[WIDTH-1];
      sb_n = md.b[WIDTH-1];
      opb_n = md.MDCtrl == MD_MULT ? mag(md.a) : mag(md.b);
      mq_n = md.MDCtrl == MD_MULT ? mag(md.b) : mag(md.a);
      acc_n = '0;
      cnt_n = '0;
      state_n = CALC;
    end else if (state == CALC) begin
      acc_n = op == MD_MULT ? sum[WIDTH:1] : (ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0]);
      mq_n = op == MD_MULT ? {sum[0], mq[WIDTH-1:1]} : {mq[WIDTH-2:0], ge};
      cnt_n = cnt + 1'b1;
      state_n = cnt == CW'(WIDTH - 1) ? FIX : CALC;
    end else if (state == FIX) begin
      hi_n = op == MD_MULT ? prod[2*WIDTH-1:WIDTH] : (sa ? -acc : acc);
      lo_n = op == MD_MULT ? prod[WIDTH-1:0] : ((sa ^ sb) ? -mq : mq);
      done_n = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op <= MD_MULT;
      sa <= 1'b0;
      sb <= 1'b0;
      acc <= '0;
      mq <= '0;
      opb <= '0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      sa <= sa_n;
      sb <= sb_n;
      acc <= acc_n;
      mq <= mq_n;
      opb <= opb_n;
      cnt <= cnt_n;
      hi <= hi_n;
      lo <= lo_n;
      done <= done_n;
    end
  end
  assign md.hi = hi;
  assign md.lo = lo;
  assign md.done = done;
  assign md.busy = state != IDLE;
  assign md.div0 = (md.MDCtrl == MD_DIV) && (md.b == '0);
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for the multiply/divide unit
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  mult_div_unit_if #(.WIDTH(32)) md();
  mult_div_unit #(.WIDTH(32)) dut(.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;

  task automatic run_op(input logic op, input logic [31:0] x, input logic [31:0] y, input int poke,
                        output logic [31:0] rh, output logic [31:0] rl, output int dk, output int bn, output int dn);
    dk = -1;
    bn = 0;
    dn = 0;
    rh = 'x;
    rl = 'x;
    @(negedge clk);
    md.MDCtrl = op;
    md.a = x;
    md.b = y;
    md.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      md.start = (k == poke);
      if (k == poke) begin
        md.a = 32'd5;
        md.b = 32'd5;
        md.MDCtrl = ~op;
      end
      if (md.busy) bn++;
      if (md.done) begin
        dn++;
        if (dk < 0) begin
          dk = k;
          rh = md.hi;
          rl = md.lo;
        end
      end
    end
    md.start = 1'b0;
  endtask

  task automatic test_reset;
    md.start = 1'b0;
    md.MDCtrl = 1'b0;
    md.a = '0;
    md.b = '0;
    repeat (3) @(negedge clk);
    total += 4;
    if (md.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got %h want 0", md.hi); end
    if (md.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got %h want 0", md.lo); end
    if (md.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", md.busy); end
    if (md.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", md.done); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    logic [31:0] rh, rl;
    int dk, bn, dn;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, -1, rh, rl, dk, bn, dn);
    total += 5;
    if (rh !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got %h want ffffffff", rh); end
    if (rl !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got %h want ffffffeb", rl); end
    if (dk !== 33) begin bad++; $display("FAIL mult_latency got %0d want 33", dk); end
    if (bn !== 33) begin bad++; $display("FAIL mult_busy_cycles got %0d want 33", bn); end
    if (dn !== 1) begin bad++; $display("FAIL mult_done_count got %0d want 1", dn); end
  endtask

  task automatic test_div;
    logic [31:0] rh, rl;
    int dk, bn, dn;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, -1, rh, rl, dk, bn, dn);
    total += 4;
    if (rl !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo got %h want fffffffd", rl); end
    if (rh !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi got %h want ffffffff", rh); end
    if (dk !== 33) begin bad++; $display("FAIL div_latency got %0d want 33", dk); end
    if (dn !== 1) begin bad++; $display("FAIL div_done_count got %0d want 1", dn); end
    run_op(1'b1, 32'd100, 32'd7, -1, rh, rl, dk, bn, dn);
    total += 2;
    if (rl !== 32'd14) begin bad++; $display("FAIL div_pos_lo got %h want 0000000e", rl); end
    if (rh !== 32'd2) begin bad++; $display("FAIL div_pos_hi got %h want 00000002", rh); end
  endtask

  task automatic test_div0;
    logic [31:0] rh, rl;
    int dk, bn, dn;
    @(negedge clk);
    md.MDCtrl = 1'b1;
    md.a = 32'd5;
    md.b = 32'd0;
    #1;
    total++;
    if (md.div0 !== 1'b1) begin bad++; $display("FAIL div0_flag got %b want 1", md.div0); end
    run_op(1'b1, 32'd5, 32'd0, -1, rh, rl, dk, bn, dn);
    total += 4;
    if (bn !== 0) begin bad++; $display("FAIL div0_busy got %0d want 0", bn); end
    if (dn !== 0) begin bad++; $display("FAIL div0_done got %0d want 0", dn); end
    if (md.hi !== 32'd2) begin bad++; $display("FAIL div0_hi_hold got %h want 00000002", md.hi); end
    if (md.lo !== 32'd14) begin bad++; $display("FAIL div0_lo_hold got %h want 0000000e", md.lo); end
    md.MDCtrl = 1'b0;
    #1;
    total++;
    if (md.div0 !== 1'b0) begin bad++; $display("FAIL div0_mult_flag got %b want 0", md.div0); end
  endtask

  task automatic test_boundary;
    logic [31:0] rh, rl;
    int dk, bn, dn;
    run_op(1'b0, 32'h80000000, 32'h80000000, -1, rh, rl, dk, bn, dn);
    total += 2;
    if (rh !== 32'h40000000) begin bad++; $display("FAIL min_sq_hi got %h want 40000000", rh); end
    if (rl !== 32'h0) begin bad++; $display("FAIL min_sq_lo got %h want 00000000", rl); end
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, rh, rl, dk, bn, dn);
    total += 2;
    if (rl !== 32'h80000000) begin bad++; $display("FAIL ovf_lo got %h want 80000000", rl); end
    if (rh !== 32'h0) begin bad++; $display("FAIL ovf_hi got %h want 00000000", rh); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rh, rl;
    int dk, bn, dn;
    run_op(1'b0, 32'd1000, 32'hFFFFFFFE, 10, rh, rl, dk, bn, dn);
    total += 4;
    if (rh !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_hi got %h want ffffffff", rh); end
    if (rl !== 32'hFFFFF830) begin bad++; $display("FAIL b2b_lo got %h want fffff830", rl); end
    if (dn !== 1) begin bad++; $display("FAIL b2b_done_count got %0d want 1", dn); end
    if (dk !== 33) begin bad++; $display("FAIL b2b_latency got %0d want 33", dk); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rh, rl;
    int dk, bn, dn;
    @(negedge clk);
    md.MDCtrl = 1'b1;
    md.a = 32'd100;
    md.b = 32'd7;
    md.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      md.start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total += 4;
    if (md.hi !== 32'h0) begin bad++; $display("FAIL abort_hi got %h want 0", md.hi); end
    if (md.lo !== 32'h0) begin bad++; $display("FAIL abort_lo got %h want 0", md.lo); end
    if (md.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", md.busy); end
    if (md.done !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", md.done); end
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md.done) dn++;
    end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", dn); end
    run_op(1'b0, 32'd3, 32'd4, -1, rh, rl, dk, bn, dn);
    total += 3;
    if (rl !== 32'd12) begin bad++; $display("FAIL post_reset_lo got %h want 0000000c", rl); end
    if (rh !== 32'h0) begin bad++; $display("FAIL post_reset_hi got %h want 00000000", rh); end
    if (dk !== 33) begin bad++; $display("FAIL post_reset_latency got %0d want 33", dk); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
